leading_ones_tracker: RTL and testbench

//  Pipelined, parametrised bit-position encoder for switch/flag vectors with valid/ready handshake.
//  Per sample it reports the highest set bit (MODE_HIGH) or the lowest set bit (MODE_LOW), selected per sample.

---
 rtl/definitions_pkg.sv | 9 +
 rtl/bit_locate.sv | 28 ++
 rtl/leading_ones_tracker.sv | 134 +++++++++++++
 tb/tb_leading_ones_tracker.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/definitions_pkg.sv
// Shared types for the leading_ones_tracker slice: per-sample scan mode and
// peak-hold tracker states.
package definitions_pkg;

    typedef enum logic {MODE_HIGH, MODE_LOW} lo_mode_t;

    typedef enum logic [1:0] {PK_IDLE, PK_HOLD, PK_DECAY} peak_state_t;

endpackage

// File: rtl/bit_locate.sv
// Combinational bit-position encoder: returns (index of highest or lowest set
// bit) + 1, or 0 when the vector is empty.
module bit_locate
    import definitions_pkg::*;
#(
    parameter  int BITS = 16,
    localparam int IW   = $clog2(BITS) + 1
) (
    input  logic [BITS-1:0] vec,
    input  lo_mode_t        mode,
    output logic [IW-1:0]   idx
);

    // The last match in scan order wins, so the scan direction selects the end.
    always_comb begin
        idx = '0;
        if (mode == MODE_HIGH) begin
            for (int i = 0; i < BITS; i++) begin
                if (vec[i]) idx = IW'(i + 1);
            end
        end else begin
            for (int i = BITS - 1; i >= 0; i--) begin
                if (vec[i]) idx = IW'(i + 1);
            end
        end
    end

endmodule

// File: rtl/leading_ones_tracker.sv
// Two-stage valid/ready bit-position encoder with optional peak-hold tracker.
// Peak tracker is built only when LO_PEAK_HOLD_EN is defined.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   PK_IDLE  | peak is 0, waiting for a nonzero transfer
//   PK_HOLD  | peak frozen; one step down after HOLD_CYCLES clocks
//   PK_DECAY | peak steps down by one every HOLD_CYCLES clocks until 0
module leading_ones_tracker
    import definitions_pkg::*;
#(
    parameter  int BITS        = 16,
    parameter  int HOLD_CYCLES = 1000,
    localparam int IW          = $clog2(BITS) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] in_data,
    input  lo_mode_t        in_mode,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [IW-1:0]   out_idx,
    output logic            out_valid,
    input  logic            out_ready,
    input  logic            clear,
    output logic [IW-1:0]   peak_idx
);

    logic            stall;
    logic            s1_valid;
    logic [BITS-1:0] s1_data;
    lo_mode_t        s1_mode;
    logic [IW-1:0]   enc_idx;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_mode   <= MODE_HIGH;
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else if (!stall) begin
            s1_valid  <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_mode <= in_mode;
            end
            out_valid <= s1_valid;
            if (s1_valid) out_idx <= enc_idx;
        end
    end

    bit_locate #(.BITS(BITS)) u_locate (
        .vec  (s1_data),
        .mode (s1_mode),
        .idx  (enc_idx)
    );

`ifdef LO_PEAK_HOLD_EN
    localparam int TW = $clog2(HOLD_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(HOLD_CYCLES - 1);

    peak_state_t   state, state_nxt;
    logic [IW-1:0] peak, peak_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          xfer;
    logic          expire;

    assign xfer     = out_valid & out_ready;
    assign expire   = (timer == T_LAST);
    assign peak_idx = peak;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PK_IDLE;
            peak  <= '0;
            timer <= '0;
        end else begin
            state <= state_nxt;
            peak  <= peak_nxt;
            timer <= timer_nxt;
        end
    end

    // Every step, including the first out of HOLD, comes after HOLD_CYCLES
    // clocks at the current level, so the bar graph falls at a uniform rate.
    always_comb begin
        state_nxt = state;
        peak_nxt  = peak;
        timer_nxt = (&timer) ? timer : timer + 1'b1;
        unique case (state)
            PK_IDLE: begin
                peak_nxt  = '0;
                timer_nxt = '0;
                if (xfer && out_idx != '0) begin
                    peak_nxt  = out_idx;
                    state_nxt = PK_HOLD;
                end
            end
            PK_HOLD, PK_DECAY: begin
                if (xfer && (out_idx > peak || (state == PK_HOLD && out_idx == peak))) begin
                    peak_nxt  = out_idx;
                    timer_nxt = '0;
                    state_nxt = PK_HOLD;
                end else if (expire) begin
                    peak_nxt  = peak - 1'b1;
                    timer_nxt = '0;
                    state_nxt = (peak == IW'(1)) ? PK_IDLE : PK_DECAY;
                end
            end
            default: begin
                state_nxt = PK_IDLE;
                peak_nxt  = '0;
                timer_nxt = '0;
            end
        endcase
        if (clear) begin
            state_nxt = PK_IDLE;
            peak_nxt  = '0;
            timer_nxt = '0;
        end
    end
`else
    localparam int unused_hold_cycles = HOLD_CYCLES;
    logic unused_clear;

    assign unused_clear = clear;
    assign peak_idx     = out_idx;
`endif

endmodule

// File: tb/tb_leading_ones_tracker.sv
// Self-checking bench for leading_ones_tracker (BITS=16, HOLD_CYCLES=4); peak
// decay scenarios run when LO_PEAK_HOLD_EN is defined.
module tb_leading_ones_tracker;
    import definitions_pkg::*;

    localparam int BITS = 16;
    localparam int HOLD = 4;
    localparam int IW   = $clog2(BITS) + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [BITS-1:0] in_data;
    lo_mode_t        in_mode;
    logic            in_valid;
    logic            in_ready;
    logic [IW-1:0]   out_idx;
    logic            out_valid;
    logic            out_ready;
    logic            clear;
    logic [IW-1:0]   peak_idx;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    leading_ones_tracker #(.BITS(BITS), .HOLD_CYCLES(HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .clear     (clear),
        .peak_idx  (peak_idx)
    );

    // Reference encoding: highest set bit k -> k+1 = clog2(v+1); the lowest
    // set bit is isolated with v & -v first.
    function automatic int ref_idx(input int unsigned v, input bit low);
        int unsigned x;
        x = low ? (v & (~v + 1)) : v;
        return $clog2(x + 1);
    endfunction

    function automatic logic [BITS-1:0] rand_vec();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return BITS'(1) << $urandom_range(0, BITS - 1);
            2:       return BITS'($urandom);
            default: return BITS'($urandom & $urandom);
        endcase
    endfunction

    // Scoreboard plus peak model: peak loads on a larger transfer (or equal
    // while it has not yet started falling), otherwise steps down one every
    // HOLD clocks until zero.
    int exp_q[$];
    int m_peak = 0;
    int m_age = 0;
    bit m_stepped = 1'b0;
    logic rst_q = 1'b1;

    always @(posedge clk) begin
        int e;
        rst_q <= reset;
        if (reset) begin
            exp_q.delete();
            m_peak <= 0; m_age <= 0; m_stepped <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL xfer_order: got idx %0d, required no transfer (nothing pending)", out_idx);
                end else begin
                    e = exp_q.pop_front();
                    if (out_idx !== IW'(e)) begin
                        n_bad++;
                        $display("FAIL xfer_value: got idx %0d, required %0d", out_idx, e);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_idx(32'(in_data), in_mode == MODE_LOW));
            if (clear) begin
                m_peak <= 0; m_age <= 0; m_stepped <= 1'b0;
            end else if (out_valid && out_ready && out_idx != 0 &&
                         (int'(out_idx) > m_peak || (int'(out_idx) == m_peak && !m_stepped))) begin
                m_peak <= int'(out_idx); m_age <= 0; m_stepped <= 1'b0;
            end else if (m_peak != 0) begin
                if (m_age == HOLD - 1) begin
                    m_peak <= m_peak - 1; m_age <= 0; m_stepped <= 1'b1;
                end else begin
                    m_age <= m_age + 1;
                end
            end
        end
    end

    bit            prev_stall = 1'b0;
    logic [IW-1:0] prev_idx = '0;

    always @(negedge clk) begin
        #1;
        if (rst_q) prev_stall = 1'b0;
        if (!reset) begin
            n_cmp++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                n_bad++;
                $display("FAIL in_ready_rule: got %0b, required %0b", in_ready, !(out_valid && !out_ready));
            end
            if (prev_stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_idx !== prev_idx) begin
                    n_bad++;
                    $display("FAIL stall_hold: got valid %0b idx %0d, required valid 1 idx %0d", out_valid, out_idx, prev_idx);
                end
            end
            n_cmp++;
`ifdef LO_PEAK_HOLD_EN
            if (peak_idx !== IW'(m_peak)) begin
                n_bad++;
                $display("FAIL peak_model: got %0d, required %0d", peak_idx, m_peak);
            end
`else
            if (peak_idx !== out_idx) begin
                n_bad++;
                $display("FAIL peak_follow: got %0d, required %0d", peak_idx, out_idx);
            end
`endif
        end
        prev_stall = !reset && out_valid && !out_ready;
        prev_idx   = out_idx;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clear = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = MODE_HIGH;
        out_ready = 1'b0; clear = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || out_idx !== '0 || peak_idx !== '0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state: got valid %0b idx %0d peak %0d rdy %0b, required 0 0 0 1",
                     out_valid, out_idx, peak_idx, in_ready);
        end
        reset = 1'b0;
    endtask

    task automatic test_zero_latency();
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_data = '0; in_mode = MODE_HIGH;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_early: got out_valid %0b one clock after accept, required 0", out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_idx !== '0) begin
            n_bad++;
            $display("FAIL latency_zero: got valid %0b idx %0d, required valid 1 idx 0", out_valid, out_idx);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [BITS-1:0] d[3];
        lo_mode_t        m[3];
        int              e[3];
        d[0] = 16'h0001; m[0] = MODE_HIGH; e[0] = 1;
        d[1] = 16'h8001; m[1] = MODE_LOW;  e[1] = 1;
        d[2] = 16'h8001; m[2] = MODE_HIGH; e[2] = 16;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_idx !== IW'(e[k-2])) begin
                    n_bad++;
                    $display("FAIL b2b_%0d: got valid %0b idx %0d, required valid 1 idx %0d",
                             k - 2, out_valid, out_idx, e[k-2]);
                end
            end
            in_valid = (k < 3);
            if (k < 3) begin in_data = d[k]; in_mode = m[k]; end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_stall();
        logic [BITS-1:0] d[3];
        d[0] = 16'h0040; d[1] = 16'h0400; d[2] = 16'h2000;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_mode = MODE_HIGH; in_data = d[0];
        @(negedge clk);
        in_data = d[1];
        @(negedge clk);
        in_data = d[2];
        repeat (3) begin
            #1;
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_idx !== IW'(7)) begin
                n_bad++;
                $display("FAIL stall_state: got rdy %0b valid %0b idx %0d, required rdy 0 valid 1 idx 7",
                         in_ready, out_valid, out_idx);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_idx !== IW'(11)) begin
            n_bad++;
            $display("FAIL stall_release1: got valid %0b idx %0d, required valid 1 idx 11", out_valid, out_idx);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_idx !== IW'(14)) begin
            n_bad++;
            $display("FAIL stall_release2: got valid %0b idx %0d, required valid 1 idx 14", out_valid, out_idx);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_nodup: got out_valid %0b after drain, required 0", out_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = rand_vec();
            in_mode   = lo_mode_t'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            clear     = ($urandom_range(0, 49) == 0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1; clear = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL random_drain: got %0d samples still pending, required 0", exp_q.size());
        end
    endtask

`ifdef LO_PEAK_HOLD_EN
    task automatic test_peak_decay();
        bit seen;
        do_reset();
        out_ready = 1'b1; in_mode = MODE_HIGH;
        in_valid = 1'b1; in_data = 16'h0100;
        @(negedge clk);
        in_data = 16'h0004;
        @(negedge clk);
        in_valid = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = (peak_idx == IW'(9));
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL peak_load: got peak %0d within 20 clocks, required 9", peak_idx);
        end else begin
            for (int v = 9; v >= 1; v--) begin
                for (int k = 0; k < HOLD; k++) begin
                    n_cmp++;
                    if (peak_idx !== IW'(v)) begin
                        n_bad++;
                        $display("FAIL peak_step_%0d_%0d: got %0d, required %0d", v, k, peak_idx, v);
                    end
                    @(negedge clk);
                end
            end
            repeat (6) begin
                n_cmp++;
                if (peak_idx !== '0) begin
                    n_bad++;
                    $display("FAIL peak_idle: got %0d, required 0", peak_idx);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_clear();
        do_reset();
        out_ready = 1'b1; in_mode = MODE_HIGH;
        in_valid = 1'b1; in_data = 16'h0010;
        @(negedge clk);
        in_data = 16'h0800;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (peak_idx !== IW'(5) || out_idx !== IW'(12) || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_setup: got peak %0d idx %0d valid %0b, required 5 12 1", peak_idx, out_idx, out_valid);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (2 * HOLD) begin
            n_cmp++;
            if (peak_idx !== '0) begin
                n_bad++;
                $display("FAIL clear_wins: got peak %0d, required 0", peak_idx);
            end
            @(negedge clk);
        end
    endtask
`endif

    task automatic test_reset_midflight();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_mode = MODE_HIGH; in_data = 16'h0200;
        @(negedge clk);
        in_data = 16'h1000;
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || peak_idx !== '0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid: got valid %0b peak %0d rdy %0b, required 0 0 1", out_valid, peak_idx, in_ready);
        end
        reset = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_drop: got out_valid %0b after reset, required 0", out_valid);
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_data = '0; in_mode = MODE_HIGH; in_valid = 1'b0;
        out_ready = 1'b0; clear = 1'b0;
        test_reset();
        test_zero_latency();
        test_back_to_back();
        test_stall();
        test_random();
`ifdef LO_PEAK_HOLD_EN
        test_peak_decay();
        test_clear();
`endif
        test_reset_midflight();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
